csa_job_dispatch: RTL and testbench
===================================

// Module: csa_job_dispatch
// PURPOSE
//  Upstream feeder of the CSA input FIFO. Software programs one job (block, 48-bit calc input, total times, chunk size,
//  start base) over the AXI-MM register port; block splits it into records of <= CHUNK times and pushes each as
//  5 x 32-bit words into the input FIFO drained by the CSA calc array. Runs entirely on axi_mm_clk.
// PARAMETERS
//  AXI_DATA_WIDTH     32   register / FIFO word width (only 32 supported)
//  OPT_MEM_ADDR_BITS  10   register address width
//  CSA_CALC_IN_WIDTH  48   calc input width; word2 = zero-padded upper (CSA_CALC_IN_WIDTH-32) bits
// PORTS
//  axi_mm_clk     in   1     clock
//  rst_n          in   1     synchronous, active-low reset
//  wen/wstrb      in   1/4   register write strobe / byte enables
//  waddr/wdata    in   10/32 register write address / data
//  ren/raddr      in   1/10  register read strobe / address
//  rdata          out  32    register read data, 1-cycle latency
//  csa_in_w_full  in   1     input FIFO full
//  csa_in_wclk    out  1     = axi_mm_clk
//  csa_in_wen     out  1     FIFO write enable
//  csa_in_wdata   out  32    FIFO write data
// BEHAVIOUR
//  Reset value of every output is 0 (incl. rdata, csa_in_wen, csa_in_wdata); FSM -> IDLE, all regs/counters 0.
//  Regs (word addr): 0 CTRL W (b0 START, b1 ABORT; acted on only if wstrb[0]); 1 STATUS R {b0 busy, b1 done,
//   b2 aborted, b3 err_chunk0}; 2 BLOCK; 3 IN_LO; 4 IN_HI [15:0]; 5 TOTAL; 6 CHUNK; 7 START_BASE (2-7 R/W,
//   per-byte wstrb); 8 ISSUED R (records fully pushed, this job). Other raddr -> {16'hE000, 6'b0, raddr}.
//  Read with ren=0: rdata holds. CTRL reads 0.
//  START in IDLE: clear done/aborted/err/ISSUED; CHUNK==0 -> set err_chunk0, stay IDLE; TOTAL==0 -> set done,
//   no records; else snapshot regs 2-7 into working copies, remaining=TOTAL, cur_start=START_BASE -> W0.
//  START while busy ignored. Reg writes while busy update shadow regs only; running job unaffected.
//  States: IDLE, W0..W4, NEXT. Word Wk issued in a cycle only if csa_in_w_full==0 (wen=1, wdata valid same cycle,
//   advance); else wen=0, hold. W0 BLOCK, W1 IN_LO, W2 {16'b0,IN_HI}, W3 times=min(CHUNK,remaining),
//   W4 cur_start. Record word order never changes; words never skipped.
//  NEXT (1 cycle, wen=0): remaining-=times; cur_start+=times (mod 2^32 wrap, no flag); ISSUED+=1;
//   remaining==0 -> done=1, IDLE; abort_pend -> aborted=1, IDLE; else W0.
//  ABORT while busy: latch abort_pend; current record completes (FIFO stays 5-word aligned), then IDLE.
//   ABORT in IDLE ignored. START+ABORT same write in IDLE: START only.
//  Throughput with FIFO never full: 6 cycles/record; first wen 1 cycle after START write.
//  Reset mid-record: wen drops next edge; partial record left in FIFO -- FIFO must share rst_n.
//  busy=1 in all states except IDLE.
// TESTING
//  TOTAL=10,CHUNK=4,BASE=100, full=0 -> 3 records, times/start = 4/100,4/104,2/108; done=1, ISSUED=3.
//  full toggled every other cycle during job -> same word sequence, no dup/loss, wen never with full=1.
//  CHUNK=0 START -> no wen, STATUS=0x8; TOTAL=0 START -> no wen, STATUS=0x2.
//  ABORT during W2 of record 2 (TOTAL=100,CHUNK=10) -> record 2 completes, ISSUED=2, STATUS=0x4.
//  BASE=0xFFFFFFFE,CHUNK=2,TOTAL=6 -> starts FFFFFFFE,0,2; write BLOCK mid-job -> not seen in job words.
//  rst_n low during W3 -> next edge wen=0, rdata=0, STATUS=0; read raddr=0x3FF -> 0xE00003FF.

Source files
------------

// File: rtl/csa_job_dispatch_if.sv
// Register port and input-FIFO write port of the CSA job dispatcher.
// slave = dispatcher side, master = software/FIFO side.
interface csa_job_dispatch_if #(
   parameter int AXI_DATA_WIDTH    = 32,
   parameter int OPT_MEM_ADDR_BITS = 10
);
   logic                          wen;
   logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
   logic [OPT_MEM_ADDR_BITS-1:0]  waddr;
   logic [AXI_DATA_WIDTH-1:0]     wdata;
   logic                          ren;
   logic [OPT_MEM_ADDR_BITS-1:0]  raddr;
   logic [AXI_DATA_WIDTH-1:0]     rdata;
   logic                          csa_in_w_full;
   logic                          csa_in_wclk;
   logic                          csa_in_wen;
   logic [AXI_DATA_WIDTH-1:0]     csa_in_wdata;

   modport slave (
      input  wen, wstrb, waddr, wdata, ren, raddr, csa_in_w_full,
      output rdata, csa_in_wclk, csa_in_wen, csa_in_wdata
   );

   modport master (
      output wen, wstrb, waddr, wdata, ren, raddr, csa_in_w_full,
      input  rdata, csa_in_wclk, csa_in_wen, csa_in_wdata
   );
endinterface

// File: rtl/csa_job_dispatch.sv
// CSA job dispatcher: software programs one job over the register port; the
// job is split into records of at most CHUNK times and each record is pushed
// as five 32-bit words (BLOCK, IN_LO, IN_HI, times, start) into the input FIFO.
module csa_job_dispatch #(
   parameter int AXI_DATA_WIDTH    = 32,
   parameter int OPT_MEM_ADDR_BITS = 10,
   parameter int CSA_CALC_IN_WIDTH = 48
) (
   input  logic               axi_mm_clk,
   input  logic               rst_n,
   csa_job_dispatch_if.slave  bus
);
   localparam int DW   = AXI_DATA_WIDTH;
   localparam int HI_W = CSA_CALC_IN_WIDTH - 32;
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_CTRL   = OPT_MEM_ADDR_BITS'(0);
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_STATUS = OPT_MEM_ADDR_BITS'(1);
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_BLOCK  = OPT_MEM_ADDR_BITS'(2);
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_IN_LO  = OPT_MEM_ADDR_BITS'(3);
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_IN_HI  = OPT_MEM_ADDR_BITS'(4);
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_TOTAL  = OPT_MEM_ADDR_BITS'(5);
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_CHUNK  = OPT_MEM_ADDR_BITS'(6);
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_BASE   = OPT_MEM_ADDR_BITS'(7);
   localparam logic [OPT_MEM_ADDR_BITS-1:0] A_ISSUED = OPT_MEM_ADDR_BITS'(8);

   typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3, S_W4, S_NEXT} state_t;

   state_t             r_state;
   // shadow registers, freely writable even while a job runs
   logic [DW-1:0]      r_block, r_in_lo, r_total, r_chunk, r_base;
   logic [HI_W-1:0]    r_in_hi;
   // working copies of the running job
   logic [DW-1:0]      r_j_block, r_j_in_lo, r_j_chunk, r_rem, r_cur;
   logic [HI_W-1:0]    r_j_in_hi;
   logic [DW-1:0]      r_issued;
   logic               r_done, r_aborted, r_err, r_abort_pend;
   logic [DW-1:0]      r_rdata;

   logic               w_ctrl_wr, w_start, w_abort, w_busy, w_wen;
   logic [DW-1:0]      w_times, w_wdata, w_hi_wr;

   // merge new write data into an old value under the byte enables
   function automatic logic [DW-1:0] f_bw(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [DW/8-1:0] strb);
      logic [DW-1:0] v;
      v = old_v;
      for (int b = 0; b < DW/8; b++)
         if (strb[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
      return v;
   endfunction

   assign w_ctrl_wr = bus.wen && (bus.waddr == A_CTRL) && bus.wstrb[0];
   assign w_start   = w_ctrl_wr && bus.wdata[0];
   assign w_abort   = w_ctrl_wr && bus.wdata[1];
   assign w_busy    = (r_state != S_IDLE);
   assign w_times   = (r_j_chunk < r_rem) ? r_j_chunk : r_rem;
   assign w_hi_wr   = f_bw(DW'(r_in_hi), bus.wdata, bus.wstrb);

   // FIFO word select; a word is written only in a cycle the FIFO is not full
   always_comb begin
      w_wdata = '0;
      w_wen   = 1'b0;
      case (r_state)
         S_W0:    w_wdata = r_j_block;
         S_W1:    w_wdata = r_j_in_lo;
         S_W2:    w_wdata = DW'(r_j_in_hi);
         S_W3:    w_wdata = w_times;
         S_W4:    w_wdata = r_cur;
         default: w_wdata = '0;
      endcase
      if (r_state inside {S_W0, S_W1, S_W2, S_W3, S_W4}) w_wen = !bus.csa_in_w_full;
   end

   assign bus.csa_in_wclk  = axi_mm_clk;
   assign bus.csa_in_wen   = w_wen;
   assign bus.csa_in_wdata = w_wdata;
   assign bus.rdata        = r_rdata;

   // shadow register writes with per-byte enables
   always_ff @(posedge axi_mm_clk) begin
      if (!rst_n) begin
         r_block <= '0; r_in_lo <= '0; r_in_hi <= '0;
         r_total <= '0; r_chunk <= '0; r_base  <= '0;
      end else if (bus.wen) begin
         case (bus.waddr)
            A_BLOCK: r_block <= f_bw(r_block, bus.wdata, bus.wstrb);
            A_IN_LO: r_in_lo <= f_bw(r_in_lo, bus.wdata, bus.wstrb);
            A_IN_HI: r_in_hi <= w_hi_wr[HI_W-1:0];
            A_TOTAL: r_total <= f_bw(r_total, bus.wdata, bus.wstrb);
            A_CHUNK: r_chunk <= f_bw(r_chunk, bus.wdata, bus.wstrb);
            A_BASE:  r_base  <= f_bw(r_base,  bus.wdata, bus.wstrb);
            default: ;
         endcase
      end
   end

   // job FSM: snapshot on START, emit five words per record, account in NEXT
   always_ff @(posedge axi_mm_clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_j_block <= '0; r_j_in_lo <= '0; r_j_in_hi <= '0; r_j_chunk <= '0;
         r_rem     <= '0; r_cur     <= '0; r_issued  <= '0;
         r_done    <= 1'b0; r_aborted <= 1'b0; r_err <= 1'b0; r_abort_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_done <= 1'b0; r_aborted <= 1'b0; r_err <= 1'b0;
               r_issued <= '0; r_abort_pend <= 1'b0;
               if (r_chunk == '0)      r_err  <= 1'b1;
               else if (r_total == '0) r_done <= 1'b1;
               else begin
                  r_j_block <= r_block; r_j_in_lo <= r_in_lo; r_j_in_hi <= r_in_hi;
                  r_j_chunk <= r_chunk; r_rem     <= r_total; r_cur     <= r_base;
                  r_state   <= S_W0;
               end
            end
            S_W0: if (!bus.csa_in_w_full) r_state <= S_W1;
            S_W1: if (!bus.csa_in_w_full) r_state <= S_W2;
            S_W2: if (!bus.csa_in_w_full) r_state <= S_W3;
            S_W3: if (!bus.csa_in_w_full) r_state <= S_W4;
            S_W4: if (!bus.csa_in_w_full) r_state <= S_NEXT;
            S_NEXT: begin
               r_rem    <= r_rem - w_times;
               r_cur    <= r_cur + w_times;
               r_issued <= r_issued + 1'b1;
               if (r_rem == w_times) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else if (r_abort_pend) begin
                  r_aborted <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_state <= S_W0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         // abort is deferred to the record boundary so the FIFO stays 5-word aligned
         if (w_busy && w_abort) r_abort_pend <= 1'b1;
      end
   end

   // registered read port; rdata holds when no read is requested
   always_ff @(posedge axi_mm_clk) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (bus.ren) begin
         case (bus.raddr)
            A_CTRL:   r_rdata <= '0;
            A_STATUS: r_rdata <= DW'({r_err, r_aborted, r_done, w_busy});
            A_BLOCK:  r_rdata <= r_block;
            A_IN_LO:  r_rdata <= r_in_lo;
            A_IN_HI:  r_rdata <= DW'(r_in_hi);
            A_TOTAL:  r_rdata <= r_total;
            A_CHUNK:  r_rdata <= r_chunk;
            A_BASE:   r_rdata <= r_base;
            A_ISSUED: r_rdata <= r_issued;
            default:  r_rdata <= DW'({16'hE000, 6'b0, bus.raddr});
         endcase
      end
   end
endmodule

// File: tb/tb_csa_job_dispatch.sv
// Directed bench for csa_job_dispatch: register access, record splitting,
// FIFO back-pressure, error/abort paths, start-address wrap and reset.
module tb_csa_job_dispatch;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          viol   = 0;
   logic        tog_en = 1'b0;
   logic        tog_ph = 1'b0;
   logic [31:0] cap [$];
   logic [31:0] rd;

   csa_job_dispatch_if bus ();

   csa_job_dispatch dut (
      .axi_mm_clk (clk),
      .rst_n      (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // FIFO full: toggles every cycle when enabled, changes just after the edge
   always @(posedge clk) begin
      #1;
      tog_ph = ~tog_ph;
      bus.csa_in_w_full = tog_en & tog_ph;
   end

   // FIFO model: capture every accepted word, flag any write into a full FIFO
   always @(negedge clk) begin
      if (bus.csa_in_wen === 1'b1) begin
         cap.push_back(bus.csa_in_wdata);
         if (bus.csa_in_w_full !== 1'b0) viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      bus.wen = 1'b1; bus.waddr = a; bus.wdata = d; bus.wstrb = s;
      @(negedge clk);
      bus.wen = 1'b0; bus.wstrb = 4'h0;
   endtask

   task automatic rdr(input logic [9:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.ren = 1'b1; bus.raddr = a;
      @(negedge clk);
      bus.ren = 1'b0;
      d = bus.rdata;
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      s = 32'd1;
      for (int i = 0; i < 300 && s[0]; i++) rdr(10'd1, s);
      chk("idle_wait", {31'b0, s[0]}, 32'd0);
   endtask

   task automatic chk_rec(input int r, input logic [31:0] blk, input logic [31:0] lo,
                          input logic [31:0] hi, input logic [31:0] tm, input logic [31:0] st);
      chk($sformatf("rec%0d_block", r), cap[r*5+0], blk);
      chk($sformatf("rec%0d_in_lo", r), cap[r*5+1], lo);
      chk($sformatf("rec%0d_in_hi", r), cap[r*5+2], hi);
      chk($sformatf("rec%0d_times", r), cap[r*5+3], tm);
      chk($sformatf("rec%0d_start", r), cap[r*5+4], st);
   endtask

   initial begin
      bus.wen = 1'b0; bus.wstrb = 4'h0; bus.waddr = 10'd0; bus.wdata = 32'd0;
      bus.ren = 1'b0; bus.raddr = 10'd0;

      // reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wen",   32'(bus.csa_in_wen), 32'd0);
      chk("rst_wdata", bus.csa_in_wdata,    32'd0);
      chk("rst_rdata", bus.rdata,           32'd0);
      rst_n = 1'b1;
      rdr(10'd1, rd); chk("rst_status", rd, 32'd0);

      // job 1: TOTAL=10 CHUNK=4 BASE=100, FIFO never full
      wr(10'd2, 32'h0000B10C, 4'hF);
      wr(10'd3, 32'h11223344, 4'hF);
      wr(10'd4, 32'h00005566, 4'hF);
      wr(10'd5, 32'd10, 4'hF);
      wr(10'd6, 32'd4, 4'hF);
      wr(10'd7, 32'd100, 4'hF);
      rdr(10'd5, rd); chk("rd_total", rd, 32'd10);
      rdr(10'd4, rd); chk("rd_in_hi", rd, 32'h00005566);
      wr(10'd0, 32'd1, 4'hF);
      chk("first_wen", 32'(bus.csa_in_wen), 32'd1);
      wait_idle();
      chk("j1_words", 32'(cap.size()), 32'd15);
      chk_rec(0, 32'h0000B10C, 32'h11223344, 32'h00005566, 32'd4, 32'd100);
      chk_rec(1, 32'h0000B10C, 32'h11223344, 32'h00005566, 32'd4, 32'd104);
      chk_rec(2, 32'h0000B10C, 32'h11223344, 32'h00005566, 32'd2, 32'd108);
      rdr(10'd1, rd); chk("j1_status", rd, 32'h2);
      rdr(10'd8, rd); chk("j1_issued", rd, 32'd3);

      // job 2: same job with FIFO full toggling
      cap.delete();
      tog_en = 1'b1;
      wr(10'd0, 32'd1, 4'hF);
      wait_idle();
      tog_en = 1'b0;
      chk("j2_words", 32'(cap.size()), 32'd15);
      chk_rec(0, 32'h0000B10C, 32'h11223344, 32'h00005566, 32'd4, 32'd100);
      chk_rec(1, 32'h0000B10C, 32'h11223344, 32'h00005566, 32'd4, 32'd104);
      chk_rec(2, 32'h0000B10C, 32'h11223344, 32'h00005566, 32'd2, 32'd108);
      chk("j2_full_viol", 32'(viol), 32'd0);
      rdr(10'd8, rd); chk("j2_issued", rd, 32'd3);

      // CHUNK=0 -> err, TOTAL=0 -> done, no words either way
      cap.delete();
      wr(10'd6, 32'd0, 4'hF);
      wr(10'd0, 32'd1, 4'hF);
      repeat (4) @(negedge clk);
      rdr(10'd1, rd); chk("chunk0_status", rd, 32'h8);
      chk("chunk0_words", 32'(cap.size()), 32'd0);
      wr(10'd6, 32'd4, 4'hF);
      wr(10'd5, 32'd0, 4'hF);
      wr(10'd0, 32'd1, 4'hF);
      repeat (4) @(negedge clk);
      rdr(10'd1, rd); chk("total0_status", rd, 32'h2);
      rdr(10'd8, rd); chk("total0_issued", rd, 32'd0);
      chk("total0_words", 32'(cap.size()), 32'd0);

      // abort during W2 of record 2: record 2 completes, then stop
      cap.delete();
      wr(10'd5, 32'd100, 4'hF);
      wr(10'd6, 32'd10, 4'hF);
      wr(10'd7, 32'd100, 4'hF);
      wr(10'd0, 32'd1, 4'hF);
      repeat (7) @(negedge clk);
      wr(10'd0, 32'd2, 4'hF);
      wait_idle();
      chk("abort_words", 32'(cap.size()), 32'd10);
      chk_rec(1, 32'h0000B10C, 32'h11223344, 32'h00005566, 32'd10, 32'd110);
      rdr(10'd1, rd); chk("abort_status", rd, 32'h4);
      rdr(10'd8, rd); chk("abort_issued", rd, 32'd2);

      // start wraps past 2^32; BLOCK written mid-job must not leak into the job
      cap.delete();
      wr(10'd2, 32'h0000AAAA, 4'hF);
      wr(10'd5, 32'd6, 4'hF);
      wr(10'd6, 32'd2, 4'hF);
      wr(10'd7, 32'hFFFFFFFE, 4'hF);
      wr(10'd0, 32'd1, 4'hF);
      wr(10'd2, 32'h0000BBBB, 4'hF);
      wait_idle();
      chk("wrap_words", 32'(cap.size()), 32'd15);
      chk_rec(0, 32'h0000AAAA, 32'h11223344, 32'h00005566, 32'd2, 32'hFFFFFFFE);
      chk_rec(1, 32'h0000AAAA, 32'h11223344, 32'h00005566, 32'd2, 32'h00000000);
      chk_rec(2, 32'h0000AAAA, 32'h11223344, 32'h00005566, 32'd2, 32'h00000002);
      rdr(10'd2, rd); chk("shadow_block", rd, 32'h0000BBBB);
      wr(10'd7, 32'hAABBCCDD, 4'b0101);
      rdr(10'd7, rd); chk("byte_strobe", rd, 32'hFFBBFFDD);
      rdr(10'd0, rd); chk("ctrl_reads0", rd, 32'd0);
      wr(10'd0, 32'd1, 4'b1110);
      repeat (2) @(negedge clk);
      rdr(10'd1, rd); chk("start_nostrb", rd, 32'h2);

      // reset in the middle of a record
      wr(10'd5, 32'd10, 4'hF);
      wr(10'd6, 32'd4, 4'hF);
      wr(10'd7, 32'd100, 4'hF);
      wr(10'd0, 32'd1, 4'hF);
      repeat (3) @(negedge clk);
      chk("w3_wen",   32'(bus.csa_in_wen), 32'd1);
      chk("w3_times", bus.csa_in_wdata,    32'd4);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_wen",   32'(bus.csa_in_wen), 32'd0);
      chk("mrst_wdata", bus.csa_in_wdata,    32'd0);
      chk("mrst_rdata", bus.rdata,           32'd0);
      rst_n = 1'b1;
      rdr(10'd1, rd);     chk("mrst_status", rd, 32'd0);
      rdr(10'd8, rd);     chk("mrst_issued", rd, 32'd0);
      rdr(10'd5, rd);     chk("mrst_total",  rd, 32'd0);
      rdr(10'h3FF, rd);   chk("unmapped",    rd, 32'hE00003FF);
      rdr(10'h010, rd);   chk("unmapped2",   rd, 32'hE0000010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
